// File: rtl/cmos_cfg_sequencer.sv
// Power-up and configuration sequencer for the CMOS sensor and its I2C config engine.
// Define CMOS_PID_CHECK_EN to enable the product-ID check on the index 0->1 step.
module cmos_cfg_sequencer #(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned PWDN_CYC    = CLK_FREQ / 1000,
    parameter int unsigned RST_CYC     = CLK_FREQ / 1000,
    parameter int unsigned BOOT_CYC    = CLK_FREQ / 1000,
    parameter int unsigned TIMEOUT_CYC = CLK_FREQ / 10,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [7:0]  EXP_PID     = 8'h77
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       cmos_pwdn,
    output logic       cmos_rst_n,
    output logic       i2c_rst_n,
    input  logic [7:0] i2c_config_index,
    input  logic       i2c_config_done,
    input  logic [7:0] i2c_rdata,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_error,
    output logic [1:0] retry_cnt
);

    localparam int unsigned CNT_W = 24;

    typedef enum logic [2:0] {
        S_PWDN, S_RESET, S_BOOT, S_CONFIG, S_DONE, S_FAIL
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] phase_cnt, wdog_cnt;
    logic [7:0]       prev_index;
    logic [1:0]       retry_nx;
    logic             idx_changed, done_ok, wdog_hit, pid_bad, fault;

    assign idx_changed = i2c_config_index != prev_index;
    assign done_ok     = (state == S_CONFIG) && i2c_config_done && (phase_cnt != '0);
    assign wdog_hit    = (state == S_CONFIG) && !idx_changed
                         && (wdog_cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef CMOS_PID_CHECK_EN
    assign pid_bad = (state == S_CONFIG) && (prev_index == 8'd0)
                     && (i2c_config_index == 8'd1) && (i2c_rdata != EXP_PID);
`else
    logic unused_pid;
    assign unused_pid = ^{i2c_rdata, EXP_PID};
    assign pid_bad    = 1'b0;
`endif

    // PID mismatch outranks success, success outranks the watchdog
    assign fault = pid_bad || (wdog_hit && !done_ok);

    always_comb begin
        state_nx = state;
        retry_nx = retry_cnt;
        case (state)
            S_PWDN:   if (phase_cnt == CNT_W'(PWDN_CYC - 1)) state_nx = S_RESET;
            S_RESET:  if (phase_cnt == CNT_W'(RST_CYC - 1))  state_nx = S_BOOT;
            S_BOOT:   if (phase_cnt == CNT_W'(BOOT_CYC - 1)) state_nx = S_CONFIG;
            S_CONFIG: begin
                if (fault) begin
                    if (32'(retry_cnt) < MAX_RETRY) begin
                        retry_nx = retry_cnt + 2'd1;
                        state_nx = S_PWDN;
                    end else begin
                        state_nx = S_FAIL;
                    end
                end else if (done_ok) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE, S_FAIL: begin
                if (start) begin
                    retry_nx = 2'd0;
                    state_nx = S_PWDN;
                end
            end
            default: state_nx = S_PWDN;
        endcase
    end

    // State, counters and pins all update on the edge that enters the new state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_PWDN;
            phase_cnt  <= '0;
            wdog_cnt   <= '0;
            prev_index <= 8'd0;
            retry_cnt  <= 2'd0;
            cmos_pwdn  <= 1'b1;
            cmos_rst_n <= 1'b0;
            i2c_rst_n  <= 1'b0;
            busy       <= 1'b1;
            cfg_done   <= 1'b0;
            cfg_error  <= 1'b0;
        end else begin
            state      <= state_nx;
            retry_cnt  <= retry_nx;
            prev_index <= i2c_config_index;

            if (state_nx != state)     phase_cnt <= '0;
            else if (phase_cnt != '1)  phase_cnt <= phase_cnt + CNT_W'(1);

            if (state != S_CONFIG || state_nx != S_CONFIG || idx_changed) wdog_cnt <= '0;
            else if (wdog_cnt != '1)                                      wdog_cnt <= wdog_cnt + CNT_W'(1);

            case (state_nx)
                S_PWDN: begin
                    cmos_pwdn <= 1'b1; cmos_rst_n <= 1'b0; i2c_rst_n <= 1'b0;
                    busy      <= 1'b1; cfg_done   <= 1'b0; cfg_error <= 1'b0;
                end
                S_RESET: begin
                    cmos_pwdn <= 1'b0; cmos_rst_n <= 1'b0; i2c_rst_n <= 1'b0;
                    busy      <= 1'b1; cfg_done   <= 1'b0; cfg_error <= 1'b0;
                end
                S_BOOT: begin
                    cmos_pwdn <= 1'b0; cmos_rst_n <= 1'b1; i2c_rst_n <= 1'b0;
                    busy      <= 1'b1; cfg_done   <= 1'b0; cfg_error <= 1'b0;
                end
                S_CONFIG: begin
                    cmos_pwdn <= 1'b0; cmos_rst_n <= 1'b1; i2c_rst_n <= 1'b1;
                    busy      <= 1'b1; cfg_done   <= 1'b0; cfg_error <= 1'b0;
                end
                S_DONE: begin
                    cmos_pwdn <= 1'b0; cmos_rst_n <= 1'b1; i2c_rst_n <= 1'b1;
                    busy      <= 1'b0; cfg_done   <= 1'b1; cfg_error <= 1'b0;
                end
                default: begin
                    cmos_pwdn <= 1'b1; cmos_rst_n <= 1'b0; i2c_rst_n <= 1'b0;
                    busy      <= 1'b0; cfg_done   <= 1'b0; cfg_error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmos_cfg_sequencer.sv
// Bench for cmos_cfg_sequencer: engine stimulus model, sequence-level reference
// model checked every cycle, plus hand-computed milestones.
module tb_cmos_cfg_sequencer;

    localparam int P_CYC = 10;
    localparam int R_CYC = 10;
    localparam int B_CYC = 10;
    localparam int TO_CYC = 50;
    localparam int MAXR = 3;
    localparam int STEP = 20;
`ifdef CMOS_PID_CHECK_EN
    localparam bit PID_EN = 1'b1;
`else
    localparam bit PID_EN = 1'b0;
`endif

    logic       clk, rst, start;
    logic       cmos_pwdn, cmos_rst_n, i2c_rst_n;
    logic [7:0] i2c_config_index;
    logic       i2c_config_done;
    logic [7:0] i2c_rdata;
    logic       busy, cfg_done, cfg_error;
    logic [1:0] retry_cnt;

    cmos_cfg_sequencer #(
        .CLK_FREQ(1000), .PWDN_CYC(P_CYC), .RST_CYC(R_CYC), .BOOT_CYC(B_CYC),
        .TIMEOUT_CYC(TO_CYC), .MAX_RETRY(MAXR), .EXP_PID(8'h77)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cmos_pwdn(cmos_pwdn), .cmos_rst_n(cmos_rst_n), .i2c_rst_n(i2c_rst_n),
        .i2c_config_index(i2c_config_index), .i2c_config_done(i2c_config_done),
        .i2c_rdata(i2c_rdata), .busy(busy), .cfg_done(cfg_done),
        .cfg_error(cfg_error), .retry_cnt(retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Engine stimulus knobs
    bit         scripted = 1'b0;
    int         stall_at = 255;
    int         k_idx = 255, k_lo = -1, k_hi = -1;
    logic [7:0] pid = 8'h77;
    logic [7:0] eng_idx = 8'd0;
    int         eng_cnt = 0;
    int         cfg_cyc = -1;

    // Reference model: cycles since the sequence (re)started, outcome, retries
    int         m_seq = 0, m_term = 0, m_retry = 0, m_quiet = 0;
    logic [7:0] m_prev = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int m_phase();
        if (m_term == 1) return 4;
        if (m_term == 2) return 5;
        if (m_seq < P_CYC) return 0;
        if (m_seq < P_CYC + R_CYC) return 1;
        if (m_seq < P_CYC + R_CYC + B_CYC) return 2;
        return 3;
    endfunction

    // {pwdn, rst_n, i2c_rst_n, busy, done, error, retry}
    function automatic logic [7:0] exp_out();
        logic [1:0] r;
        r = 2'(m_retry);
        case (m_phase())
            0:       return {6'b100100, r};
            1:       return {6'b000100, r};
            2:       return {6'b010100, r};
            3:       return {6'b011100, r};
            4:       return {6'b011010, r};
            default: return {6'b100001, r};
        endcase
    endfunction

    task automatic model_reset();
        m_seq = 0; m_term = 0; m_retry = 0; m_quiet = 0; m_prev = 8'd0;
    endtask

    task automatic model_step(input logic r, input logic s, input logic [7:0] idx,
                              input logic dn, input logic [7:0] rd);
        int ph;
        bit chg, first, ok, bad;
        if (r) begin
            model_reset();
            return;
        end
        ph  = m_phase();
        chg = (idx != m_prev);
        if (ph >= 4) begin
            if (s) begin m_term = 0; m_seq = 0; m_retry = 0; end
        end else if (ph == 3) begin
            first   = (m_seq == P_CYC + R_CYC + B_CYC);
            m_quiet = chg ? 0 : m_quiet + 1;
            bad     = PID_EN && (m_prev == 8'd0) && (idx == 8'd1) && (rd != 8'h77);
            ok      = dn && !first;
            if (bad || (!ok && m_quiet >= TO_CYC)) begin
                m_quiet = 0;
                if (m_retry < MAXR) begin m_retry++; m_seq = 0; end
                else m_term = 2;
            end else if (ok) begin
                m_term = 1;
            end else begin
                m_seq++;
            end
        end else begin
            m_quiet = 0;
            m_seq++;
        end
        m_prev = idx;
    endtask

    task automatic drive_engine();
        logic dn;
        if (!i2c_rst_n) begin
            eng_idx = 8'd0; eng_cnt = 0; cfg_cyc = -1; dn = 1'b0;
        end else begin
            cfg_cyc++;
            if (scripted) begin
                eng_idx = (cfg_cyc >= k_idx) ? 8'd1 : 8'd0;
                dn = (cfg_cyc >= k_lo) && (cfg_cyc <= k_hi);
            end else begin
                eng_cnt++;
                if (eng_cnt == STEP && eng_idx < 8 && int'(eng_idx) != stall_at) begin
                    eng_idx = eng_idx + 8'd1;
                    eng_cnt = 0;
                end
                dn = (eng_idx == 8'd8);
            end
        end
        i2c_config_index = eng_idx;
        i2c_config_done  = dn;
        i2c_rdata        = pid;
    endtask

    // One cycle: compare at the negedge, drive next inputs, advance the model
    task automatic tick();
        check("outputs", {24'd0, cmos_pwdn, cmos_rst_n, i2c_rst_n, busy, cfg_done, cfg_error, retry_cnt},
              {24'd0, exp_out()});
        drive_engine();
        model_step(rst, start, i2c_config_index, i2c_config_done, i2c_rdata);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_term();
        int n;
        n = 0;
        while (!(cfg_done || cfg_error) && n < 2000) begin tick(); n++; end
        check("terminal_reached", 32'(n < 2000), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pwdn"},   32'(cmos_pwdn),  32'd1);
        check({tag, "_rst_n"},  32'(cmos_rst_n), 32'd0);
        check({tag, "_i2c"},    32'(i2c_rst_n),  32'd0);
        check({tag, "_busy"},   32'(busy),       32'd1);
        check({tag, "_done"},   32'(cfg_done),   32'd0);
        check({tag, "_err"},    32'(cfg_error),  32'd0);
        check({tag, "_retry"},  32'(retry_cnt),  32'd0);
    endtask

    task automatic count_to_config(input string tag);
        int n, t_pwdn, t_rst;
        n = 0; t_pwdn = -1; t_rst = -1;
        while (!i2c_rst_n && n < 100) begin
            tick(); n++;
            if (!cmos_pwdn && t_pwdn < 0) t_pwdn = n;
            if (cmos_rst_n && t_rst < 0)  t_rst = n;
        end
        check({tag, "_pwdn_fall"},  32'(t_pwdn), 32'd10);
        check({tag, "_rstn_rise"},  32'(t_rst),  32'd20);
        check({tag, "_cfg_entry"},  32'(n),      32'd30);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0;
        i2c_config_index = 8'd0; i2c_config_done = 1'b0; i2c_rdata = 8'h77;
        @(negedge clk);
        check_reset_vals("reset");
        tick(); tick();
        rst = 1'b0;

        // Nominal run, with a start pulse in CONFIG that must be ignored
        count_to_config("nominal");
        repeat (5) tick();
        pulse_start();
        run_to_term();
        check("nominal_done",  32'(cfg_done),  32'd1);
        check("nominal_retry", 32'(retry_cnt), 32'd0);
        check("nominal_busy",  32'(busy),      32'd0);

        // Index stalls at 3
        stall_at = 3;
        pulse_start();
        n = 0;
        while (eng_idx != 8'd3 && n < 300) begin tick(); n++; end
        n = 0;
        while (i2c_rst_n && n < 200) begin tick(); n++; end
        check("stall_to_fault", 32'(n),         32'd50);
        check("stall_retry1",   32'(retry_cnt), 32'd1);
        run_to_term();
        check("stall_error", 32'(cfg_error), 32'd1);
        check("stall_busy",  32'(busy),      32'd0);
        check("stall_retry", 32'(retry_cnt), 32'd3);

        // Start from FAIL, then a wrong product ID
        stall_at = 255;
        pid = 8'h76;
        pulse_start();
        check("start_clr_retry", 32'(retry_cnt), 32'd0);
        n = 0;
        while (cmos_pwdn && n < 40) begin tick(); n++; end
        check("start_pwdn_len", 32'(n), 32'd10);
        run_to_term();
        check("pid_done",  32'(cfg_done),  PID_EN ? 32'd0 : 32'd1);
        check("pid_retry", 32'(retry_cnt), PID_EN ? 32'd3 : 32'd0);

        // Done lands on the same cycle as the watchdog limit
        scripted = 1'b1; pid = 8'h77; k_idx = 255; k_lo = 49; k_hi = 49;
        pulse_start();
        run_to_term();
        check("tie_done",  32'(cfg_done),  32'd1);
        check("tie_retry", 32'(retry_cnt), 32'd0);

        // Done one cycle after the watchdog limit
        k_lo = 50; k_hi = 50;
        pulse_start();
        run_to_term();
        check("late_error", 32'(cfg_error), 32'd1);
        check("late_retry", 32'(retry_cnt), 32'd3);

        // Done only on the first CONFIG cycle does not count
        k_lo = 0; k_hi = 0;
        pulse_start();
        run_to_term();
        check("first_cyc_error", 32'(cfg_error), 32'd1);

        // PID mismatch together with done
        pid = 8'h76; k_idx = 5; k_lo = 5; k_hi = 5;
        pulse_start();
        run_to_term();
        check("piddone_done",  32'(cfg_done),  PID_EN ? 32'd0 : 32'd1);
        check("piddone_retry", 32'(retry_cnt), PID_EN ? 32'd3 : 32'd0);

        // Reset asserted during BOOT
        scripted = 1'b0; pid = 8'h77;
        pulse_start();
        repeat (25) tick();
        check("in_boot", 32'({cmos_pwdn, cmos_rst_n, i2c_rst_n}), 32'b010);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        model_reset();
        tick(); tick();
        rst = 1'b0;
        count_to_config("post_rst");
        run_to_term();
        check("post_rst_done",  32'(cfg_done),  32'd1);
        check("post_rst_retry", 32'(retry_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cmos_cfg_sequencer.md
# cmos_cfg_sequencer

Power-up and configuration sequencer for the CMOS sensor control path. It drives the sensor PWDN/RESET pins through a timed power-up sequence and holds the I2C configuration engine in reset until the sensor has booted. It then monitors the engine's register-index progress and checks the sensor product ID. On a stall or an ID mismatch it restarts the whole sequence, up to a retry limit. It sits between the top-level camera wrapper and the I2C timing/config-LUT pair.

## Interface
Parameters:
- CLK_FREQ, 100_000000, system clock frequency in Hz.
- PWDN_CYC, CLK_FREQ/1000, cycles in the PWDN state (1 ms).
- RST_CYC, CLK_FREQ/1000, cycles in the RESET state (1 ms).
- BOOT_CYC, CLK_FREQ/1000, cycles in the BOOT state (1 ms).
- TIMEOUT_CYC, CLK_FREQ/10, maximum cycles without an index change in CONFIG (100 ms).
- MAX_RETRY, 3, number of restarts allowed before FAIL.
- EXP_PID, 8'h77, expected product-ID byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that restarts the sequence; honoured only in DONE or FAIL.
- cmos_pwdn  out  1  sensor power-down pin, active-high.
- cmos_rst_n  out  1  sensor reset pin, active-low.
- i2c_rst_n  out  1  active-low reset to the I2C config engine.
- i2c_config_index  in  8  current LUT index from the engine.
- i2c_config_done  in  1  engine reports that every LUT entry is written.
- i2c_rdata  in  8  last byte the engine read back.
- busy  out  1  high in PWDN, RESET, BOOT and CONFIG.
- cfg_done  out  1  high in DONE.
- cfg_error  out  1  high in FAIL.
- retry_cnt  out  2  number of restarts performed in the current run.

## Operation
- States: PWDN, RESET, BOOT, CONFIG, DONE, FAIL. Reset enters PWDN, so the sequence starts automatically.
- PWDN: cmos_pwdn=1, cmos_rst_n=0, i2c_rst_n=0. Moves to RESET after PWDN_CYC cycles.
- RESET: cmos_pwdn=0, cmos_rst_n=0. Moves to BOOT after RST_CYC cycles.
- BOOT: cmos_rst_n=1. Moves to CONFIG after BOOT_CYC cycles.
- CONFIG: i2c_rst_n=1.
  - The watchdog counter clears on every cycle where i2c_config_index differs from its value on the previous cycle.
  - A fault is raised when the watchdog reaches TIMEOUT_CYC.
  - PID check: on the cycle the index goes 0→1, i2c_rdata is compared with EXP_PID. A mismatch raises a fault.
  - Success: i2c_config_done=1 on any cycle except the first cycle of CONFIG → DONE.
- Fault handling:
  - If retry_cnt < MAX_RETRY: retry_cnt increments and the state returns to PWDN. This drops i2c_rst_n and restarts the engine at index 0.
  - Otherwise → FAIL.
- DONE: outputs hold the CONFIG pin values.
- FAIL: cmos_pwdn=1, cmos_rst_n=0, i2c_rst_n=0.
- start in DONE or FAIL: retry_cnt clears to 0 and the state goes to PWDN. start in any other state is ignored.
- Simultaneous events in the same CONFIG cycle: success beats a watchdog timeout, and a PID mismatch beats success.

## Timing
- Reset values: cmos_pwdn=1, cmos_rst_n=0, i2c_rst_n=0, busy=1, cfg_done=0, cfg_error=0, retry_cnt=0. The watchdog and phase counter reset to 0.
- All outputs are registered and change on the clock edge that enters the new state.
- The phase counter is 24 bits and clears on every state change. Each timed state lasts exactly its *_CYC cycles.
- Latency from reset release to the first CONFIG cycle is PWDN_CYC+RST_CYC+BOOT_CYC cycles.
- A fault in CONFIG causes i2c_rst_n to fall on the next edge.
- Asserting rst mid-run immediately forces the reset values and discards any progress.

## Configuration
- CMOS_PID_CHECK_EN defined: the 0→1 index PID comparison is active, and a mismatch raises a fault.
- Not defined: the comparison logic is compiled out, and only the watchdog can raise a fault.

## Test plan
All scenarios use PWDN_CYC=RST_CYC=BOOT_CYC=10, TIMEOUT_CYC=50, MAX_RETRY=3.
- Nominal run: release rst; the engine model steps the index every 20 cycles and returns rdata=8'h77 at 0→1, with done at index 8. Required: pins follow the order PWDN(10), RESET(10), BOOT(10); cfg_done=1 and retry_cnt=0.
- Stall: the index freezes at 3. Required: 50 cycles later i2c_rst_n=0 and retry_cnt=1; after 3 retries cfg_error=1 and busy=0.
- PID mismatch: rdata=8'h76 at 0→1. Required: with CMOS_PID_CHECK_EN, retry_cnt increments on every attempt and the run ends in FAIL. Without it, the run ends in DONE.
- start pulse: in FAIL, retry_cnt clears to 0 and cmos_pwdn=1 for 10 cycles. In CONFIG, start is ignored.
- Simultaneous events: done and the watchdog limit land on the same cycle; required outcome is DONE. With CMOS_PID_CHECK_EN, a mismatch together with done gives a retry.
- Reset mid-run: assert rst during BOOT. Required: all outputs return to reset values within the same cycle, and a full sequence follows release.
